stage_progress: RTL and testbench

//  Game-progression tracker for Flappy, directly upstream of the LED stage display.

---
 rtl/flappy_pkg.sv | 11 +
 rtl/stage_progress_if.sv | 23 ++
 rtl/rise_detect.sv | 16 +
 rtl/stage_progress.sv | 84 ++++++++
 tb/tb_stage_progress.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// Shared Flappy game definitions: FSM state encoding and display-bus defaults.
package flappy_pkg;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PLAYING = 2'd1;
  localparam state_t ST_OVER    = 2'd2;

  localparam int MAX_STAGE = 9;
  localparam int STAGE_W   = 32;
endpackage

// File: rtl/stage_progress_if.sv
// Game-event inputs and progress outputs between the game logic and the stage tracker.
interface stage_progress_if #(
  parameter int SCORE_W = 16
);
  logic                          start_game;
  logic                          pipe_passed;
  logic                          collision;
  logic [flappy_pkg::STAGE_W-1:0] stage;
  logic [SCORE_W-1:0]            score;
  logic                          playing;
  logic                          game_over;
  logic                          stage_up;

  modport master (
    output start_game, pipe_passed, collision,
    input  stage, score, playing, game_over, stage_up
  );

  modport slave (
    input  start_game, pipe_passed, collision,
    output stage, score, playing, game_over, stage_up
  );
endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector; the history register runs every cycle regardless of game state.
module rise_detect (
  input  logic clk,
  input  logic resetN,
  input  logic din,
  output logic rise
);
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!resetN) prev_q <= 1'b0;
    else         prev_q <= din;
  end

  assign rise = din & ~prev_q;
endmodule

// File: rtl/stage_progress.sv
// Flappy progression tracker: game FSM, saturating score, and stage advance every N points.
module stage_progress #(
  parameter int POINTS_PER_STAGE = 5,
  parameter int MAX_STAGE        = flappy_pkg::MAX_STAGE,
  parameter int SCORE_W          = 16
) (
  input  logic             clk,
  input  logic             resetN,
  stage_progress_if.slave  bus
);
  import flappy_pkg::*;

  localparam int STG_W = $clog2(MAX_STAGE + 1);
  localparam int PTS_W = (POINTS_PER_STAGE > 1) ? $clog2(POINTS_PER_STAGE) : 1;

  state_t             state_q, state_d;
  logic               clear, point, rise;
  logic [SCORE_W-1:0] score_q;
  logic [STG_W-1:0]   stage_q;
  logic [PTS_W-1:0]   pts_q;
  logic               stage_up_q;

  rise_detect u_rise (
    .clk    (clk),
    .resetN (resetN),
    .din    (bus.pipe_passed),
    .rise   (rise)
  );

  // Collision takes priority over a point scored on the same edge.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    point   = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start_game) begin
          state_d = ST_PLAYING;
          clear   = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (bus.collision) state_d = ST_OVER;
        else               point   = rise;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      stage_q    <= '0;
      pts_q      <= '0;
      stage_up_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_up_q <= 1'b0;
      if (clear) begin
        score_q <= '0;
        stage_q <= '0;
        pts_q   <= '0;
      end else if (point) begin
        if (score_q != '1) score_q <= score_q + 1'b1;
        if (pts_q == PTS_W'(POINTS_PER_STAGE - 1)) begin
          pts_q <= '0;
          if (stage_q < STG_W'(MAX_STAGE)) begin
            stage_q    <= stage_q + 1'b1;
            stage_up_q <= 1'b1;
          end
        end else begin
          pts_q <= pts_q + 1'b1;
        end
      end
    end
  end

  assign bus.stage     = STAGE_W'(stage_q);
  assign bus.score     = score_q;
  assign bus.stage_up  = stage_up_q;
  assign bus.playing   = (state_q == ST_PLAYING);
  assign bus.game_over = (state_q == ST_OVER);
endmodule

// File: tb/tb_stage_progress.sv
// Directed bench for stage_progress: a 16-bit-score and a 4-bit-score instance share stimulus.
module tb_stage_progress;
  logic clk = 1'b0;
  logic resetN;
  logic start_game, pipe, coll;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  stage_progress_if #(.SCORE_W(16)) b16 ();
  stage_progress_if #(.SCORE_W(4))  b4 ();

  assign b16.start_game  = start_game;
  assign b16.pipe_passed = pipe;
  assign b16.collision   = coll;
  assign b4.start_game   = start_game;
  assign b4.pipe_passed  = pipe;
  assign b4.collision    = coll;

  stage_progress #(.POINTS_PER_STAGE(5), .MAX_STAGE(9), .SCORE_W(16)) dut (
    .clk(clk), .resetN(resetN), .bus(b16.slave)
  );
  stage_progress #(.POINTS_PER_STAGE(5), .MAX_STAGE(9), .SCORE_W(4)) dut4 (
    .clk(clk), .resetN(resetN), .bus(b4.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse followed by one low cycle; su reports stage_up seen on each cycle.
  task automatic pulse(output int su_first, output int su_second);
    pipe = 1'b1;
    step();
    su_first = int'(b16.stage_up);
    pipe = 1'b0;
    step();
    su_second = int'(b16.stage_up);
  endtask

  int a, b, su_cnt, late_su, hi_nz;

  initial begin
    resetN = 1'b0; start_game = 1'b0; pipe = 1'b0; coll = 1'b0;
    step(); step();
    chk("rst_stage", b16.stage, 0);
    chk("rst_score", 32'(b16.score), 0);
    chk("rst_play", 32'(b16.playing), 0);
    chk("rst_over", 32'(b16.game_over), 0);
    chk("rst_su", 32'(b16.stage_up), 0);

    resetN = 1'b1;
    start_game = 1'b1; step(); start_game = 1'b0;
    chk("start_play", 32'(b16.playing), 1);
    chk("start_score", 32'(b16.score), 0);

    su_cnt = 0; late_su = 0;
    for (int i = 1; i <= 5; i++) begin
      pulse(a, b);
      su_cnt += a + b;
      late_su += b;
      if (i == 4) chk("cnt_stage4", b16.stage, 0);
      if (i == 5) chk("cnt_su5", 32'(a), 1);
    end
    chk("cnt_score", 32'(b16.score), 5);
    chk("cnt_stage", b16.stage, 1);
    chk("cnt_su_total", 32'(su_cnt), 1);
    chk("cnt_su_late", 32'(late_su), 0);

    pipe = 1'b1;
    for (int i = 0; i < 10; i++) step();
    pipe = 1'b0; step();
    chk("level_score", 32'(b16.score), 6);

    // Reset held mid-game
    resetN = 1'b0;
    step(); step(); step();
    chk("mid_rst_stage", b16.stage, 0);
    chk("mid_rst_score", 32'(b16.score), 0);
    chk("mid_rst_play", 32'(b16.playing), 0);
    chk("mid_rst_over", 32'(b16.game_over), 0);
    chk("mid_rst_su", 32'(b16.stage_up), 0);
    resetN = 1'b1;

    pulse(a, b);
    chk("idle_no_pts", 32'(b16.score), 0);

    start_game = 1'b1; step(); start_game = 1'b0;
    su_cnt = 0; hi_nz = 0;
    for (int i = 1; i <= 50; i++) begin
      pulse(a, b);
      su_cnt += a + b;
      if (b16.stage[31:4] != 28'd0) hi_nz++;
      if (i == 20) chk("sat4_score20", 32'(b4.score), 15);
      if (i == 44) chk("sat_stage44", b16.stage, 8);
      if (i == 45) chk("sat_stage45", b16.stage, 9);
    end
    chk("sat_score", 32'(b16.score), 50);
    chk("sat_stage", b16.stage, 9);
    chk("sat_su_count", 32'(su_cnt), 9);
    chk("sat_hi_bits", 32'(hi_nz), 0);
    chk("sat4_score", 32'(b4.score), 15);
    chk("sat4_stage", b4.stage, 9);

    start_game = 1'b1; step(); start_game = 1'b0;
    chk("ign_start_score", 32'(b16.score), 50);
    chk("ign_start_play", 32'(b16.playing), 1);

    coll = 1'b1; step(); coll = 1'b0;
    chk("over_flag", 32'(b16.game_over), 1);
    chk("over_play", 32'(b16.playing), 0);
    chk("over_score", 32'(b16.score), 50);
    pulse(a, b);
    chk("over_hold", 32'(b16.score), 50);

    start_game = 1'b1; step(); start_game = 1'b0;
    chk("restart_play", 32'(b16.playing), 1);
    chk("restart_score", 32'(b16.score), 0);
    chk("restart_stage", b16.stage, 0);

    for (int i = 0; i < 3; i++) pulse(a, b);
    chk("pre_sim_score", 32'(b16.score), 3);
    pipe = 1'b1; coll = 1'b1; step();
    chk("sim_score", 32'(b16.score), 3);
    chk("sim_over", 32'(b16.game_over), 1);
    chk("sim_su", 32'(b16.stage_up), 0);
    pipe = 1'b0; coll = 1'b0; step();
    pulse(a, b); pulse(a, b);
    chk("sim_after", 32'(b16.score), 3);

    // A level already high when play begins must not score.
    pipe = 1'b1; step();
    start_game = 1'b1; step(); start_game = 1'b0;
    step(); step();
    chk("entry_high_play", 32'(b16.playing), 1);
    chk("entry_high_score", 32'(b16.score), 0);
    pipe = 1'b0; step();
    pulse(a, b);
    chk("entry_next_pt", 32'(b16.score), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end
endmodule
